// File: rtl/spi_defs.sv
// Shared encodings and defaults for the SPI slave receive path.
package spi_defs;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACTIVE = 2'b01,
      CHECK  = 2'b10
   } state_t;

   // {cpol, cpha}
   typedef enum logic [1:0] {
      MODE0 = 2'b00,
      MODE1 = 2'b01,
      MODE2 = 2'b10,
      MODE3 = 2'b11
   } spi_mode_t;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync.sv
// N-stage single-bit synchroniser with a configurable reset value.
// Latency STAGES clk edges; no backpressure.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk) begin
      if (rst) chain <= {STAGES{RST_VAL}};
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_sipo_rx.sv
// SPI slave receive path: latch-framed serial bits to a WIDTH-bit word, all four modes.
// Result SYNC_STAGES+2 edges after latch rises; a full word is dropped (overrun) while out_valid is held.
module spi_sipo_rx
   import spi_defs::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int CNT_W       = $clog2(WIDTH + 2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             spi_clk,
   input  logic             serial_in,
   input  logic             latch,
   input  logic             cpol,
   input  logic             cpha,
   input  logic             lsb_first,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             under_flow,
   output logic             over_flow,
   output logic             overrun,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

   logic sclk_s, sdi_s, latch_s;
   logic sclk_d, latch_d;

   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d(spi_clk), .q(sclk_s)
   );
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
      .clk(clk), .rst(rst), .d(serial_in), .q(sdi_s)
   );
   // Latch resets asserted so a frame already low at reset release never looks like a start.
   spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_latch (
      .clk(clk), .rst(rst), .d(latch), .q(latch_s)
   );

   state_t           state, state_n;
   spi_mode_t        mode_q;
   logic             cpol_q, cpha_q, lsb_q;
   logic [WIDTH-1:0] sr;
   logic [CNT_W-1:0] count;

   logic sclk_edge, leading, trailing, sample;
   logic start, shift_en, load, uf, of, ovr;

   assign {cpol_q, cpha_q} = mode_q;
   assign sclk_edge = (sclk_s != sclk_d);
   assign leading   = sclk_edge && (sclk_s != cpol_q);
   assign trailing  = sclk_edge && (sclk_s == cpol_q);
   assign sample    = cpha_q ? trailing : leading;
   assign busy      = (state == ACTIVE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n  = state;
      start    = 1'b0;
      shift_en = 1'b0;
      load     = 1'b0;
      uf       = 1'b0;
      of       = 1'b0;
      ovr      = 1'b0;
      case (state)
         IDLE: begin
            if (latch_d && !latch_s) begin
               state_n = ACTIVE;
               start   = 1'b1;
            end
         end
         ACTIVE: begin
            if (latch_s)     state_n  = CHECK;
            else if (sample) shift_en = 1'b1;
         end
         CHECK: begin
            state_n = IDLE;
            if (count == CNT_FULL) begin
               load = !out_valid || out_ready;
               ovr  = out_valid && !out_ready;
            end
            uf = (count < CNT_FULL);
            of = (count > CNT_FULL);
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_d       <= 1'b0;
         latch_d      <= 1'b0;
         mode_q       <= MODE0;
         lsb_q        <= 1'b0;
         sr           <= '0;
         count        <= '0;
         parallel_out <= '0;
         out_valid    <= 1'b0;
         under_flow   <= 1'b0;
         over_flow    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         sclk_d  <= sclk_s;
         latch_d <= latch_s;
         if (start) begin
            sr     <= '0;
            count  <= '0;
            mode_q <= spi_mode_t'({cpol, cpha});
            lsb_q  <= lsb_first;
         end else if (shift_en) begin
            // Extra bits beyond WIDTH only advance the counter so the frame reads as over-length.
            if (count < CNT_FULL)
               sr <= lsb_q ? {sdi_s, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], sdi_s};
            if (count < CNT_SAT)
               count <= count + 1'b1;
         end
         under_flow <= uf;
         over_flow  <= of;
         overrun    <= ovr;
         if (load) begin
            parallel_out <= sr;
            out_valid    <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_sipo_rx.sv
// Directed bench for spi_sipo_rx: modes, bit order, under/over-length frames, overrun, reset mid-frame.
module tb_spi_sipo_rx;

   localparam int W  = 8;
   localparam int SS = 2;
   localparam int H  = 40;

   logic         clk = 1'b0;
   logic         rst, spi_clk, serial_in, latch, cpol, cpha, lsb_first, out_ready;
   logic [W-1:0] parallel_out;
   logic         out_valid, under_flow, over_flow, overrun, busy;

   int compared   = 0;
   int mismatched = 0;
   int uf_cnt = 0, of_cnt = 0, ovr_cnt = 0, ov_cyc = 0;
   int uf0, of0, ovr0, ov0;
   int lat;

   spi_sipo_rx #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .spi_clk(spi_clk), .serial_in(serial_in),
      .latch(latch), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
      .parallel_out(parallel_out), .out_valid(out_valid), .out_ready(out_ready),
      .under_flow(under_flow), .over_flow(over_flow), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (under_flow) uf_cnt++;
      if (over_flow)  of_cnt++;
      if (overrun)    ovr_cnt++;
      if (out_valid)  ov_cyc++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      uf0 = uf_cnt; of0 = of_cnt; ovr0 = ovr_cnt; ov0 = ov_cyc;
   endtask

   task automatic frame_begin(input logic pol, input logic pha, input logic lsb);
      @(negedge clk);
      cpol = pol; cpha = pha; lsb_first = lsb; spi_clk = pol;
      #(80);
      latch = 1'b0;
      #(H);
   endtask

   task automatic send_bits(input logic [15:0] d, input int n, input logic lsb);
      logic b;
      for (int i = 0; i < n; i++) begin
         b = lsb ? d[i] : d[n-1-i];
         if (!cpha) begin
            serial_in = b; #(H);
            spi_clk = ~cpol; #(H);
            spi_clk = cpol;
         end else begin
            spi_clk = ~cpol; serial_in = b; #(H);
            spi_clk = cpol; #(H);
         end
      end
   endtask

   task automatic frame_end(output int l);
      logic         ov_p;
      logic [W-1:0] po_p;
      #(H);
      ov_p = out_valid; po_p = parallel_out;
      latch = 1'b1;
      l = 0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         if (l == 0 && (under_flow || over_flow || overrun ||
                        (out_valid && !ov_p) || parallel_out != po_p))
            l = k;
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; spi_clk = 1'b0; serial_in = 1'b0; latch = 1'b1;
      cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_po", parallel_out, 0);
      chk("rst_ov", out_valid, 0);
      chk("rst_flags", {under_flow, over_flow, overrun}, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk) rst = 1'b0;
      repeat (6) @(negedge clk);

      // Mode 0, MSB-first
      frame_begin(1'b0, 1'b0, 1'b0);
      send_bits(16'h00A5, 8, 1'b0);
      chk("t1_busy", busy, 1);
      snap();
      frame_end(lat);
      chk("t1_lat", lat, SS + 2);
      chk("t1_po", parallel_out, 8'hA5);
      chk("t1_ov_cyc", ov_cyc - ov0, 1);
      chk("t1_flags", (uf_cnt - uf0) + (of_cnt - of0) + (ovr_cnt - ovr0), 0);
      chk("t1_idle", {out_valid, busy}, 0);

      // Mode 3 LSB-first, then mode 1 MSB-first, mode 2 LSB-first
      frame_begin(1'b1, 1'b1, 1'b1);
      send_bits(16'h003C, 8, 1'b1);
      frame_end(lat);
      chk("t2_m3_po", parallel_out, 8'h3C);
      snap();
      frame_begin(1'b0, 1'b1, 1'b0);
      send_bits(16'h0081, 8, 1'b0);
      frame_end(lat);
      chk("t2_m1_po", parallel_out, 8'h81);
      chk("t2_m1_ld", ov_cyc - ov0, 1);
      snap();
      frame_begin(1'b1, 1'b0, 1'b1);
      send_bits(16'h0081, 8, 1'b1);
      frame_end(lat);
      chk("t2_m2_po", parallel_out, 8'h81);
      chk("t2_m2_ld", ov_cyc - ov0, 1);

      // Short frame
      snap();
      frame_begin(1'b0, 1'b0, 1'b0);
      send_bits(16'h0015, 5, 1'b0);
      frame_end(lat);
      chk("t3_uf", uf_cnt - uf0, 1);
      chk("t3_lat", lat, SS + 2);
      chk("t3_po", parallel_out, 8'h81);
      chk("t3_ov", ov_cyc - ov0, 0);
      chk("t3_other", (of_cnt - of0) + (ovr_cnt - ovr0), 0);

      // Long frame, then recovery
      snap();
      frame_begin(1'b0, 1'b0, 1'b0);
      send_bits(16'h02B3, 10, 1'b0);
      frame_end(lat);
      chk("t4_of", of_cnt - of0, 1);
      chk("t4_po", parallel_out, 8'h81);
      chk("t4_ov", ov_cyc - ov0, 0);
      frame_begin(1'b0, 1'b0, 1'b0);
      send_bits(16'h000F, 8, 1'b0);
      frame_end(lat);
      chk("t4_next_po", parallel_out, 8'h0F);

      // Overrun while the consumer stalls
      out_ready = 1'b0;
      frame_begin(1'b0, 1'b0, 1'b0);
      send_bits(16'h0011, 8, 1'b0);
      frame_end(lat);
      chk("t5_ov1", out_valid, 1);
      chk("t5_po1", parallel_out, 8'h11);
      snap();
      frame_begin(1'b0, 1'b0, 1'b0);
      send_bits(16'h0022, 8, 1'b0);
      frame_end(lat);
      chk("t5_ovr", ovr_cnt - ovr0, 1);
      chk("t5_po2", parallel_out, 8'h11);
      chk("t5_ov2", out_valid, 1);
      snap();
      frame_begin(1'b0, 1'b0, 1'b0);
      send_bits(16'h0033, 8, 1'b0);
      #(H);
      latch = 1'b1;
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("t5_ov3", out_valid, 1);
      chk("t5_po3", parallel_out, 8'h33);
      repeat (8) @(posedge clk);
      #1;
      chk("t5_no_ovr", ovr_cnt - ovr0, 0);
      chk("t5_ov_held", out_valid, 1);
      @(negedge clk) out_ready = 1'b1;
      @(negedge clk) out_ready = 1'b0;
      chk("t5_consumed", out_valid, 0);

      // Reset in the middle of a frame
      out_ready = 1'b1;
      frame_begin(1'b0, 1'b0, 1'b0);
      send_bits(16'h000C, 4, 1'b0);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_po", parallel_out, 0);
      rst = 1'b0;
      send_bits(16'h0007, 4, 1'b0);
      snap();
      frame_end(lat);
      chk("t6_no_evt", lat, 0);
      chk("t6_no_flags", (uf_cnt - uf0) + (of_cnt - of0) + (ovr_cnt - ovr0), 0);
      chk("t6_no_ov", ov_cyc - ov0, 0);
      chk("t6_po", parallel_out, 0);
      frame_begin(1'b0, 1'b0, 1'b0);
      send_bits(16'h005A, 8, 1'b0);
      frame_end(lat);
      chk("t6_next_po", parallel_out, 8'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
